// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared definitions for the machine-mode trap sequencer:
//               CSR addresses, cause codes, mstatus bit positions, FSM
//               state encoding and mstatus rewrite helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // CSR addresses touched by the sequencer (mie/mtvec listed for reference)
    localparam logic [11:0] c_csr_mstatus = 12'h300;
    localparam logic [11:0] c_csr_mie     = 12'h304;
    localparam logic [11:0] c_csr_mtvec   = 12'h305;
    localparam logic [11:0] c_csr_mepc    = 12'h341;
    localparam logic [11:0] c_csr_mcause  = 12'h342;

    // Synchronous exception codes
    localparam logic [3:0] c_cause_misalign_fetch = 4'd0;
    localparam logic [3:0] c_cause_illegal        = 4'd2;
    localparam logic [3:0] c_cause_ebreak         = 4'd3;
    localparam logic [3:0] c_cause_misalign_load  = 4'd4;
    localparam logic [3:0] c_cause_misalign_store = 4'd6;
    localparam logic [3:0] c_cause_ecall_m        = 4'd11;

    // Interrupt codes; these double as the mie enable bit index
    localparam logic [3:0] c_irq_msi = 4'd3;
    localparam logic [3:0] c_irq_mti = 4'd7;
    localparam logic [3:0] c_irq_mei = 4'd11;

    // mstatus field positions
    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_W_EPC    = 3'd2,
        ST_W_CAUSE  = 3'd3,
        ST_W_STATUS = 3'd4,
        ST_M_STATUS = 3'd5,
        ST_REDIRECT = 3'd6
    } trap_state_e;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r                                   = s;
        r[c_mstatus_mpie]                   = s[c_mstatus_mie];
        r[c_mstatus_mie]                    = 1'b0;
        r[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b11;
        return r;
    endfunction

    // mret: restore MIE from MPIE, set MPIE, drop MPP to user
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r                                   = s;
        r[c_mstatus_mie]                    = s[c_mstatus_mpie];
        r[c_mstatus_mpie]                   = 1'b1;
        r[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b00;
        return r;
    endfunction

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_irq_sel.sv
`default_nettype none
// ============================================================================
// Module      : trap_irq_sel
// Description : Interrupt pending/enable masking and fixed-priority encoder
//               (external > software > timer). Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_irq_sel
    import trap_ctrl_pkg::*;
(
    input  logic       global_ie,
    input  logic       commit_valid,
    input  logic       irq_sw,
    input  logic       irq_timer,
    input  logic       irq_ext,
    input  logic       en_sw,
    input  logic       en_timer,
    input  logic       en_ext,
    output logic       irq_pend,
    output logic [3:0] irq_cause
);

    logic w_sw;
    logic w_timer;
    logic w_ext;

    assign w_sw    = irq_sw    & en_sw;
    assign w_timer = irq_timer & en_timer;
    assign w_ext   = irq_ext   & en_ext;

    // An interrupt needs a committing instruction to take its PC from
    always_comb begin
        irq_pend  = global_ie & commit_valid & (w_sw | w_timer | w_ext);
        irq_cause = 4'd0;
        if (w_ext) begin
            irq_cause = c_irq_mei;
        end else if (w_sw) begin
            irq_cause = c_irq_msi;
        end else if (w_timer) begin
            irq_cause = c_irq_mti;
        end
    end

endmodule : trap_irq_sel
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Accepts exceptions, mret and
//               (optionally) interrupts, drains memory, writes mepc/mcause/
//               mstatus through the shared CSR write port and redirects
//               fetch. Idle cycles pass pipeline CSR writes straight through.
//               Build option: define TRAP_IRQ_EN to enable interrupts and
//               vectored trap targets.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret_valid,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        mem_busy,
    input  logic [31:0] mstatus,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        pipe_csr_we,
    input  logic [11:0] pipe_csr_addr,
    input  logic [31:0] pipe_csr_wdata,
    output logic        pipe_csr_stall,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        flush,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        trap_taken
);

    trap_state_e r_state;
    trap_state_e w_next_state;

    logic        r_flush;
    logic [31:0] r_epc;
    logic [31:0] r_mtvec;
    logic [3:0]  r_cause;
    logic        r_is_irq;
    logic        r_is_mret;
    logic [31:0] r_redirect_hold;

    logic        w_idle;
    logic        w_irq_pend;
    logic [3:0]  w_irq_cause;
    logic        w_take_exc;
    logic        w_take_mret;
    logic        w_take_irq;
    logic        w_accept;
    logic [31:0] w_trap_target;
    logic [31:0] w_redirect_target;

`ifdef TRAP_IRQ_EN
    trap_irq_sel u_irq_sel (
        .global_ie    (mstatus[c_mstatus_mie]),
        .commit_valid (commit_valid),
        .irq_sw       (irq_sw),
        .irq_timer    (irq_timer),
        .irq_ext      (irq_ext),
        .en_sw        (mie[c_irq_msi]),
        .en_timer     (mie[c_irq_mti]),
        .en_ext       (mie[c_irq_mei]),
        .irq_pend     (w_irq_pend),
        .irq_cause    (w_irq_cause)
    );

    // Only the three machine interrupt enables are consulted
    logic w_unused_mie;
    assign w_unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};
`else
    assign w_irq_pend  = 1'b0;
    assign w_irq_cause = 4'd0;

    // Interrupt-only inputs have no consumer without interrupt support
    logic w_unused_irq;
    assign w_unused_irq = ^{irq_sw, irq_timer, irq_ext, commit_valid, mie, r_mtvec[1:0]};
`endif

    // Event arbitration in IDLE: exception > mret > interrupt
    assign w_idle      = (r_state == ST_IDLE);
    assign w_take_exc  = w_idle & exc_valid;
    assign w_take_mret = w_idle & ~exc_valid & mret_valid;
    assign w_take_irq  = w_idle & ~exc_valid & ~mret_valid & w_irq_pend;
    assign w_accept    = w_take_exc | w_take_mret | w_take_irq;

    // Trap target: direct base, or base + 4*cause for vectored interrupts
    always_comb begin
        w_trap_target = {r_mtvec[31:2], 2'b00};
`ifdef TRAP_IRQ_EN
        if (r_is_irq && (r_mtvec[1:0] == 2'b01)) begin
            w_trap_target = {r_mtvec[31:2], 2'b00} + {26'd0, r_cause, 2'b00};
        end
`endif
    end

    // mret returns to the live mepc value seen during REDIRECT
    assign w_redirect_target = r_is_mret ? mepc : w_trap_target;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Event capture, registered flush and last-redirect hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush         <= 1'b0;
            r_epc           <= 32'd0;
            r_mtvec         <= 32'd0;
            r_cause         <= 4'd0;
            r_is_irq        <= 1'b0;
            r_is_mret       <= 1'b0;
            r_redirect_hold <= RESET_PC;
        end else begin
            r_flush <= w_accept;
            if (w_take_exc) begin
                r_epc     <= exc_pc;
                r_cause   <= exc_cause;
                r_is_irq  <= 1'b0;
                r_is_mret <= 1'b0;
                r_mtvec   <= mtvec;
            end else if (w_take_mret) begin
                r_is_irq  <= 1'b0;
                r_is_mret <= 1'b1;
            end else if (w_take_irq) begin
                r_epc     <= commit_pc;
                r_cause   <= w_irq_cause;
                r_is_irq  <= 1'b1;
                r_is_mret <= 1'b0;
                r_mtvec   <= mtvec;
            end
            if (r_state == ST_REDIRECT) begin
                r_redirect_hold <= w_redirect_target;
            end
        end
    end

    // Next-state and CSR-port/redirect decode
    always_comb begin
        w_next_state   = r_state;
        csr_we         = 1'b0;
        csr_waddr      = 12'd0;
        csr_wdata      = 32'd0;
        pipe_csr_stall = ~w_idle & pipe_csr_we;
        redirect_valid = 1'b0;
        redirect_pc    = r_redirect_hold;
        trap_taken     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The faulting or squashed instruction must never write
                if (!w_accept) begin
                    csr_we    = pipe_csr_we;
                    csr_waddr = pipe_csr_addr;
                    csr_wdata = pipe_csr_wdata;
                end
                if (w_take_mret) begin
                    w_next_state = ST_M_STATUS;
                end else if (w_take_exc || w_take_irq) begin
                    w_next_state = mem_busy ? ST_DRAIN : ST_W_EPC;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy) begin
                    w_next_state = ST_W_EPC;
                end
            end
            ST_W_EPC: begin
                csr_we       = 1'b1;
                csr_waddr    = c_csr_mepc;
                csr_wdata    = {r_epc[31:2], 2'b00};
                w_next_state = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                csr_we       = 1'b1;
                csr_waddr    = c_csr_mcause;
                csr_wdata    = {r_is_irq, 27'd0, r_cause};
                w_next_state = ST_W_STATUS;
            end
            ST_W_STATUS: begin
                csr_we       = 1'b1;
                csr_waddr    = c_csr_mstatus;
                csr_wdata    = mstatus_on_trap(mstatus);
                w_next_state = ST_REDIRECT;
            end
            ST_M_STATUS: begin
                csr_we       = 1'b1;
                csr_waddr    = c_csr_mstatus;
                csr_wdata    = mstatus_on_mret(mstatus);
                w_next_state = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = w_redirect_target;
                trap_taken     = ~r_is_mret;
                w_next_state   = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign flush = r_flush;
    assign busy  = ~w_idle;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl. Inputs change
//               just after the rising edge; outputs are checked mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    localparam logic [31:0] c_reset_pc = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        irq_sw;
    logic        irq_timer;
    logic        irq_ext;
    logic        mem_busy;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        pipe_csr_we;
    logic [11:0] pipe_csr_addr;
    logic [31:0] pipe_csr_wdata;
    logic        pipe_csr_stall;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_taken;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] hold_pc;

    trap_ctrl #(.RESET_PC(c_reset_pc)) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .mret_valid     (mret_valid),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .irq_sw         (irq_sw),
        .irq_timer      (irq_timer),
        .irq_ext        (irq_ext),
        .mem_busy       (mem_busy),
        .mstatus        (mstatus),
        .mie            (mie),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .pipe_csr_we    (pipe_csr_we),
        .pipe_csr_addr  (pipe_csr_addr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_csr_stall (pipe_csr_stall),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .flush          (flush),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_taken     (trap_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks every output; the #1 lets combinational paths settle
    task automatic expect_out(input string tag, input logic e_flush, input logic e_busy,
                              input logic e_we, input logic [11:0] e_addr,
                              input logic [31:0] e_data, input logic e_stall,
                              input logic e_rv, input logic [31:0] e_rpc, input logic e_tt);
        #1;
        chk({tag, "/flush"}, 32'(flush), 32'(e_flush));
        chk({tag, "/busy"},  32'(busy), 32'(e_busy));
        chk({tag, "/we"},    32'(csr_we), 32'(e_we));
        chk({tag, "/addr"},  32'(csr_waddr), 32'(e_addr));
        chk({tag, "/data"},  csr_wdata, e_data);
        chk({tag, "/stall"}, 32'(pipe_csr_stall), 32'(e_stall));
        chk({tag, "/rv"},    32'(redirect_valid), 32'(e_rv));
        chk({tag, "/rpc"},   redirect_pc, e_rpc);
        chk({tag, "/tt"},    32'(trap_taken), 32'(e_tt));
    endtask

    initial begin
        rst = 1'b1;
        exc_valid = 1'b0; exc_cause = 4'd0; exc_pc = 32'd0;
        mret_valid = 1'b0; commit_valid = 1'b0; commit_pc = 32'd0;
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; mem_busy = 1'b0;
        mstatus = 32'h8; mie = 32'd0; mtvec = 32'h200; mepc = 32'd0;
        pipe_csr_we = 1'b0; pipe_csr_addr = 12'd0; pipe_csr_wdata = 32'd0;
        hold_pc = c_reset_pc;

        // Reset state
        cyc(); cyc();
        expect_out("reset", 0, 0, 0, 12'h000, 32'h0, 0, 0, c_reset_pc, 0);
        rst = 1'b0;

        // Idle pass-through of a pipeline CSR write
        cyc();
        pipe_csr_we = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h0000_ABCD;
        expect_out("pass", 0, 0, 1, 12'h305, 32'h0000_ABCD, 0, 0, hold_pc, 0);

        // Ecall, no drain
        cyc();
        pipe_csr_we = 1'b0; pipe_csr_addr = 12'd0; pipe_csr_wdata = 32'd0;
        exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h100;
        expect_out("ecall.T", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);
        cyc(); exc_valid = 1'b0;
        expect_out("ecall.T1", 1, 1, 1, 12'h341, 32'h100, 0, 0, hold_pc, 0);
        cyc(); expect_out("ecall.T2", 0, 1, 1, 12'h342, 32'hB, 0, 0, hold_pc, 0);
        cyc(); expect_out("ecall.T3", 0, 1, 1, 12'h300, 32'h1880, 0, 0, hold_pc, 0);
        cyc(); expect_out("ecall.T4", 0, 1, 0, 12'h000, 32'h0, 0, 1, 32'h200, 1);
        hold_pc = 32'h200;
        cyc(); expect_out("ecall.T5", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);

        // Mret
        mstatus = 32'h1880; mepc = 32'h104; mret_valid = 1'b1;
        expect_out("mret.T", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);
        cyc(); mret_valid = 1'b0;
        expect_out("mret.T1", 1, 1, 1, 12'h300, 32'h88, 0, 0, hold_pc, 0);
        cyc(); expect_out("mret.T2", 0, 1, 0, 12'h000, 32'h0, 0, 1, 32'h104, 0);
        hold_pc = 32'h104;
        cyc(); expect_out("mret.T3", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);

        // Timer interrupt with global MIE clear is never taken
        mstatus = 32'h0; mie = 32'h80; irq_timer = 1'b1; commit_valid = 1'b1; commit_pc = 32'h40;
        cyc(); expect_out("irqmask.T1", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);

        // Vectored timer interrupt
        mstatus = 32'h8; mtvec = 32'h201;
`ifdef TRAP_IRQ_EN
        cyc(); irq_timer = 1'b0; commit_valid = 1'b0;
        expect_out("virq.T1", 1, 1, 1, 12'h341, 32'h40, 0, 0, hold_pc, 0);
        cyc(); expect_out("virq.T2", 0, 1, 1, 12'h342, 32'h8000_0007, 0, 0, hold_pc, 0);
        cyc(); expect_out("virq.T3", 0, 1, 1, 12'h300, 32'h1880, 0, 0, hold_pc, 0);
        cyc(); expect_out("virq.T4", 0, 1, 0, 12'h000, 32'h0, 0, 1, 32'h21C, 1);
        hold_pc = 32'h21C;
        cyc(); expect_out("virq.T5", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);
`else
        cyc(); irq_timer = 1'b0; commit_valid = 1'b0;
        expect_out("noirq.T1", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);
        cyc(); expect_out("noirq.T2", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);
`endif

        // Drain: mem_busy for three cycles, pipe write held throughout
        mtvec = 32'h200; mie = 32'd0;
        cyc();
        exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h303; mem_busy = 1'b1;
        pipe_csr_we = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h0000_DEAD;
        expect_out("drain.T", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);
        cyc(); exc_valid = 1'b0;
        expect_out("drain.T1", 1, 1, 0, 12'h000, 32'h0, 1, 0, hold_pc, 0);
        cyc(); expect_out("drain.T2", 0, 1, 0, 12'h000, 32'h0, 1, 0, hold_pc, 0);
        cyc(); mem_busy = 1'b0;
        expect_out("drain.T3", 0, 1, 0, 12'h000, 32'h0, 1, 0, hold_pc, 0);
        cyc(); expect_out("drain.T4", 0, 1, 1, 12'h341, 32'h300, 1, 0, hold_pc, 0);
        cyc(); expect_out("drain.T5", 0, 1, 1, 12'h342, 32'h2, 1, 0, hold_pc, 0);
        cyc(); expect_out("drain.T6", 0, 1, 1, 12'h300, 32'h1880, 1, 0, hold_pc, 0);
        cyc(); expect_out("drain.T7", 0, 1, 0, 12'h000, 32'h0, 1, 1, 32'h200, 1);
        hold_pc = 32'h200;
        cyc(); expect_out("drain.T8", 0, 0, 1, 12'h305, 32'h0000_DEAD, 0, 0, hold_pc, 0);
        pipe_csr_we = 1'b0; pipe_csr_addr = 12'd0; pipe_csr_wdata = 32'd0;

        // Collision: exception, mret, external irq and pipe write together
        cyc();
        mie = 32'h800; irq_ext = 1'b1; commit_valid = 1'b1; commit_pc = 32'h504;
        exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h500; mret_valid = 1'b1;
        pipe_csr_we = 1'b1; pipe_csr_addr = 12'h300; pipe_csr_wdata = 32'h1234;
        expect_out("coll.T", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);
        cyc();
        exc_valid = 1'b0; mret_valid = 1'b0; irq_ext = 1'b0; commit_valid = 1'b0;
        pipe_csr_we = 1'b0; pipe_csr_addr = 12'd0; pipe_csr_wdata = 32'd0;
        expect_out("coll.T1", 1, 1, 1, 12'h341, 32'h500, 0, 0, hold_pc, 0);
        cyc(); expect_out("coll.T2", 0, 1, 1, 12'h342, 32'h3, 0, 0, hold_pc, 0);
        cyc(); expect_out("coll.T3", 0, 1, 1, 12'h300, 32'h1880, 0, 0, hold_pc, 0);
        cyc(); expect_out("coll.T4", 0, 1, 0, 12'h000, 32'h0, 0, 1, 32'h200, 1);
        hold_pc = 32'h200;
        cyc(); expect_out("coll.T5", 0, 0, 0, 12'h000, 32'h0, 0, 0, hold_pc, 0);

        // Reset asserted during W_CAUSE aborts the sequence
        mie = 32'd0;
        exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h100;
        cyc(); exc_valid = 1'b0;
        expect_out("rstmid.T1", 1, 1, 1, 12'h341, 32'h100, 0, 0, hold_pc, 0);
        cyc(); rst = 1'b1;
        expect_out("rstmid.T2", 0, 1, 1, 12'h342, 32'hB, 0, 0, hold_pc, 0);
        cyc(); rst = 1'b0;
        expect_out("rstmid.T3", 0, 0, 0, 12'h000, 32'h0, 0, 0, c_reset_pc, 0);
        cyc(); expect_out("rstmid.T4", 0, 0, 0, 12'h000, 32'h0, 0, 0, c_reset_pc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_trap_ctrl
`default_nettype wire
